// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD time-of-day counter advanced by a 1 Hz tick, with a frozen set mode.
module time_keeper #(
  parameter logic [7:0] RESET_HOUR = 8'h00,
  parameter logic [7:0] RESET_MIN  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       day_tick
);
  logic       set_prev;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic [7:0] sec_base;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    return v == lim ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  always_comb begin
    sec_wrap  = sec_bcd == 8'h59;
    min_wrap  = min_bcd == 8'h59;
    hour_wrap = hour_bcd == 8'h23;
    sec_base  = set_en && !set_prev ? 8'h00 : sec_bcd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_bcd  <= 8'h00;
      min_bcd  <= RESET_MIN;
      hour_bcd <= RESET_HOUR;
      day_tick <= 1'b0;
      set_prev <= 1'b0;
    end else begin
      set_prev <= set_en;
      day_tick <= !set_en && tick && sec_wrap && min_wrap && hour_wrap;
      if (set_en) begin
        sec_bcd <= set_inc && set_sel == 2'd0 ? bcd_inc(sec_base, 8'h59) : sec_base;
        if (set_inc && set_sel == 2'd1) min_bcd <= bcd_inc(min_bcd, 8'h59);
        if (set_inc && set_sel == 2'd2) hour_bcd <= bcd_inc(hour_bcd, 8'h23);
      end else if (tick) begin
        sec_bcd <= bcd_inc(sec_bcd, 8'h59);
        if (sec_wrap) min_bcd <= bcd_inc(min_bcd, 8'h59);
        if (sec_wrap && min_wrap) hour_bcd <= bcd_inc(hour_bcd, 8'h23);
      end
    end
  end
endmodule
